alarm_set_ctrl: RTL
===================

# alarm_set_ctrl

Sequencing controller for the alarm clock's modulo up/down counters: time-hours, time-minutes, alarm-hours and alarm-minutes.
- Turns mode/up/down buttons into single-cycle inc/dec pulses for the counter selected by the current mode.
- Advances the time-minute counter on the minute timebase and carries into hours.
- Provides hold-to-repeat auto-increment and a set-mode inactivity timeout.
- Sits between the synchronized button inputs and the four counter instances.

## Interface
Parameters:
- MIN_MAX, 60, modulus of the time-minute counter; carry into hours occurs when time_min == MIN_MAX-1.
- HOLD_TICKS, 8, ticks a button must be held before auto-repeat starts.
- REPEAT_TICKS, 2, ticks between auto-repeat pulses.
- TIMEOUT_TICKS, 30, idle ticks in a set mode before returning to NORMAL.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mode_btn  in  1  synchronized, debounced level.
- up_btn  in  1  synchronized, debounced level.
- dn_btn  in  1  synchronized, debounced level.
- tick  in  1  one-cycle timebase pulse for repeat, timeout and blink.
- min_tick  in  1  one-cycle pulse, once per minute.
- time_min  in  $clog2(MIN_MAX)  current time-minute count.
- tm_hr_inc, tm_hr_dec, tm_min_inc, tm_min_dec  out  1 each  time counter controls.
- al_hr_inc, al_hr_dec, al_min_inc, al_min_dec  out  1 each  alarm counter controls.
- mode  out  3  0=NORMAL, 1=SET_HR, 2=SET_MIN, 3=SET_AHR, 4=SET_AMIN.
- blink  out  1  display blink enable.

## Operation
- Edge detect: each button has a registered previous value. A press is btn & ~btn_q.
- Mode FSM: a mode press advances NORMAL→SET_HR→SET_MIN→SET_AHR→SET_AMIN→NORMAL. Encodings 5–7 are unreachable; if ever present they go to NORMAL next cycle.
- Set modes:
  - An up press emits one inc pulse to the selected counter; a dn press emits one dec pulse.
  - up and dn both high, or both pressed in the same cycle: no pulse, and the hold counter is cleared.
- NORMAL: up/dn are ignored.
- Priority: a mode press beats up/dn in the same cycle. up/dn are ignored that cycle, and the hold and timeout counters clear.
- Timekeeping:
  - min_tick in NORMAL, SET_AHR or SET_AMIN pulses tm_min_inc.
  - If time_min == MIN_MAX-1 in that same cycle, tm_hr_inc also pulses.
  - In SET_HR and SET_MIN, min_tick is dropped (time frozen while editing); it is not queued.
- Timeout:
  - Counts ticks in set modes; clears on any up/dn/mode level high.
  - Reaching TIMEOUT_TICKS forces mode to NORMAL.
- blink: toggles on each tick in set modes; forced to 0 in NORMAL.
- Reset: mode=NORMAL; all inc/dec, blink and counters 0; button history 0, so a button held through reset registers as a press on the first cycle after release of rst.

## Timing
- All outputs are registered.
- An event sampled at edge N (press, tick, min_tick) produces its output at N+1, high exactly one cycle.
- Mode changes are visible at N+1. A press in the cycle after a mode change targets the new counter.
- At most one of inc/dec per counter is high in any cycle.
- tm_min_inc and a user tm_min_* pulse cannot collide, because user time edits occur only in frozen modes.
- Auto-repeat (when compiled in):
  - The hold count increments on tick while exactly one of up/dn is held in a set mode.
  - When it reaches HOLD_TICKS, a pulse is emitted.
  - After that, a pulse is emitted every REPEAT_TICKS ticks.
  - Release clears the hold count.
- Hold, repeat and timeout counters saturate and never wrap.
- rst asserted mid-operation clears all outputs immediately (asynchronously), with no partial pulse.

## Configuration
- AUTOREPEAT_EN defined: hold-to-repeat logic as above.
- Not defined: only press edges generate pulses, and hold/repeat counters are removed. HOLD_TICKS and REPEAT_TICKS are ignored. Timeout and timekeeping are unchanged.

## Test plan
- Reset, then 5 mode presses → mode steps 1,2,3,4,0, each one cycle after its press; blink 0 in NORMAL.
- mode=SET_MIN, up press → tm_min_inc high for 1 cycle at N+1. dn press → tm_min_dec. min_tick in the same window → no tm_min_inc.
- NORMAL, time_min=59, min_tick → tm_min_inc and tm_hr_inc both high in the same single cycle. With time_min=58 → only tm_min_inc.
- AUTOREPEAT_EN, mode=SET_AHR, up held for 14 ticks → al_hr_inc pulses after the initial press, then at tick 8, 10, 12 and 14. Without the macro → only the first pulse.
- mode=SET_HR, no buttons for 30 ticks → mode returns to 0. A button press at tick 29 restarts the count.
- mode press and up press in the same cycle in SET_HR → mode=2, no tm_hr_inc. rst low mid-hold → all outputs 0 immediately.

Source files
------------

// File: rtl/alarm_set_ctrl.sv
// Mode/set sequencer for the alarm clock's four modulo counters: button edges to inc/dec pulses,
// minute timekeeping with hour carry, set-mode timeout and blink. AUTOREPEAT_EN adds hold-to-repeat.
module alarm_set_ctrl #(
    parameter int MIN_MAX       = 60,
    parameter int HOLD_TICKS    = 8,
    parameter int REPEAT_TICKS  = 2,
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode_btn,
    input  logic                       up_btn,
    input  logic                       dn_btn,
    input  logic                       tick,
    input  logic                       min_tick,
    input  logic [$clog2(MIN_MAX)-1:0] time_min,
    output logic                       tm_hr_inc,
    output logic                       tm_hr_dec,
    output logic                       tm_min_inc,
    output logic                       tm_min_dec,
    output logic                       al_hr_inc,
    output logic                       al_hr_dec,
    output logic                       al_min_inc,
    output logic                       al_min_dec,
    output logic [2:0]                 mode,
    output logic                       blink
);
    localparam int MW   = $clog2(MIN_MAX);
    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        NORMAL   = 3'd0,
        SET_HR   = 3'd1,
        SET_MIN  = 3'd2,
        SET_AHR  = 3'd3,
        SET_AMIN = 3'd4
    } mode_e;

    mode_e             state_q, state_d;
    logic              mode_btn_q, up_btn_q, dn_btn_q;
    logic [TO_W-1:0]   to_q, to_d;
    logic              blink_q, blink_d;
    // {tm_hr_inc, tm_hr_dec, tm_min_inc, tm_min_dec, al_hr_inc, al_hr_dec, al_min_inc, al_min_dec}
    logic [7:0]        pulse_q, pulse_d;

    logic mode_press, up_press, dn_press;
    logic set_mode, inc_req, dec_req, tk_ok, carry;
    logic rpt_up, rpt_dn;
    logic [3:0] sel;

    assign mode_press = mode_btn & ~mode_btn_q;
    assign up_press   = up_btn & ~up_btn_q;
    assign dn_press   = dn_btn & ~dn_btn_q;
    assign set_mode   = state_q inside {SET_HR, SET_MIN, SET_AHR, SET_AMIN};

    // A mode press swallows any up/dn activity in the same cycle.
    assign inc_req = set_mode & ~mode_press & ((up_press & ~dn_btn) | rpt_up);
    assign dec_req = set_mode & ~mode_press & ((dn_press & ~up_btn) | rpt_dn);

    // Time is frozen while the user edits time-hours or time-minutes.
    assign tk_ok = min_tick & (state_q inside {NORMAL, SET_AHR, SET_AMIN});
    assign carry = tk_ok & (time_min == MW'(MIN_MAX - 1));

`ifdef AUTOREPEAT_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          held, rpt_fire;

    assign held = set_mode & ~mode_press & (up_btn ^ dn_btn);

    always_comb begin
        hold_d   = hold_q;
        rep_d    = rep_q;
        rpt_fire = 1'b0;
        if (!held) begin
            hold_d = '0;
            rep_d  = '0;
        end else if (tick) begin
            if (hold_q < HW'(HOLD_TICKS)) begin
                hold_d   = hold_q + 1'b1;
                rpt_fire = (hold_q == HW'(HOLD_TICKS - 1));
            end else if (rep_q >= RW'(REPEAT_TICKS - 1)) begin
                rep_d    = '0;
                rpt_fire = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            rep_q  <= '0;
        end else begin
            hold_q <= hold_d;
            rep_q  <= rep_d;
        end
    end

    assign rpt_up = rpt_fire & up_btn;
    assign rpt_dn = rpt_fire & dn_btn;
`else
    // Hold/repeat settings have no effect in this build.
    logic unused_cfg;
    assign unused_cfg = ^{HOLD_TICKS, REPEAT_TICKS};
    assign rpt_up     = 1'b0;
    assign rpt_dn     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        to_d    = '0;
        sel     = 4'b0000;
        case (state_q)
            NORMAL:   if (mode_press) state_d = SET_HR;
            SET_HR:   begin sel = 4'b1000; if (mode_press) state_d = SET_MIN;  end
            SET_MIN:  begin sel = 4'b0100; if (mode_press) state_d = SET_AHR;  end
            SET_AHR:  begin sel = 4'b0010; if (mode_press) state_d = SET_AMIN; end
            SET_AMIN: begin sel = 4'b0001; if (mode_press) state_d = NORMAL;   end
            default:  state_d = NORMAL;
        endcase

        // Any button level counts as activity; the counter stops one short so it never overflows.
        if (set_mode && !(mode_btn || up_btn || dn_btn)) begin
            to_d = to_q;
            if (tick) begin
                if (to_q >= TO_W'(TIMEOUT_TICKS - 1)) begin
                    state_d = NORMAL;
                    to_d    = '0;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
        end

        blink_d = blink_q;
        if (state_d == NORMAL) blink_d = 1'b0;
        else if (tick && set_mode) blink_d = ~blink_q;

        pulse_d = {carry | (sel[3] & inc_req), sel[3] & dec_req,
                   tk_ok | (sel[2] & inc_req), sel[2] & dec_req,
                   sel[1] & inc_req,           sel[1] & dec_req,
                   sel[0] & inc_req,           sel[0] & dec_req};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= NORMAL;
            mode_btn_q <= 1'b0;
            up_btn_q   <= 1'b0;
            dn_btn_q   <= 1'b0;
            to_q       <= '0;
            blink_q    <= 1'b0;
            pulse_q    <= '0;
        end else begin
            state_q    <= state_d;
            mode_btn_q <= mode_btn;
            up_btn_q   <= up_btn;
            dn_btn_q   <= dn_btn;
            to_q       <= to_d;
            blink_q    <= blink_d;
            pulse_q    <= pulse_d;
        end
    end

    assign {tm_hr_inc, tm_hr_dec, tm_min_inc, tm_min_dec,
            al_hr_inc, al_hr_dec, al_min_inc, al_min_dec} = pulse_q;
    assign mode  = state_q;
    assign blink = blink_q;

endmodule
